// File: rtl/clock_pkg.sv
// Shared constants and FSM state encodings for the digital clock's input conditioning logic.
package clock_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } debState_e;

   localparam int CLK_FREQ_HZ = 50_000_000;
   localparam int DEBOUNCE_MS = 10;

   // Timing defaults scale with the system clock: 10 ms settle, 1 s repeat delay, 200 ms repeat rate.
   localparam int DEFAULT_STABLE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
   localparam int DEFAULT_REPEAT_DELAY  = CLK_FREQ_HZ;
   localparam int DEFAULT_REPEAT_PERIOD = CLK_FREQ_HZ / 5;

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous input; reset value is configurable so the
// chain can come out of reset holding the input's idle level.
module bit_synchronizer #(
   parameter int STAGES    = 2,
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizer, stability-count debounce FSM, registered level and
// press/release pulses. Define BUTTON_DEBOUNCER_AUTOREPEAT_EN to add held-button auto-repeat.
module button_debouncer
   import clock_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int SYNC_STAGES   = 2,
   parameter bit ACTIVE_LOW    = 1'b1,
   parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

   logic             syncOut;
   logic             pressed;
   debState_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             level_q;
   logic             press_q;
   logic             release_q;

   // The chain resets to the released level so reset never looks like a press.
   bit_synchronizer #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (ACTIVE_LOW)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (btn_raw),
      .q_o   (syncOut)
   );

   assign pressed = syncOut ^ ACTIVE_LOW;

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
   localparam int REP_W = $clog2(maxInt(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

   logic [REP_W-1:0] rep_q;
   logic             repArmed_q;
   logic             repPeriodic_q;
   logic             acceptPress;
   logic             holding;
   logic             repeatFire;

   assign acceptPress = (state_q == PRESS_WAIT) && pressed && (cnt_q == CNT_TERM);
   assign holding     = (state_q == PRESSED) && pressed;
   assign repeatFire  = holding && repArmed_q &&
                        (rep_q == (repPeriodic_q ? REP_NEXT : REP_FIRST));

   // Repeat timing is armed only by a genuine accepted press; a bounce back from RELEASE_WAIT
   // returns to PRESSED disarmed, so a flaky release cannot start a fresh repeat train.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q         <= '0;
         repArmed_q    <= 1'b0;
         repPeriodic_q <= 1'b0;
      end else if (acceptPress) begin
         rep_q         <= '0;
         repArmed_q    <= 1'b1;
         repPeriodic_q <= 1'b0;
      end else if (holding && repArmed_q) begin
         if (repeatFire) begin
            rep_q         <= '0;
            repPeriodic_q <= 1'b1;
         end else begin
            rep_q <= rep_q + 1'b1;
         end
      end else begin
         rep_q         <= '0;
         repArmed_q    <= 1'b0;
         repPeriodic_q <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pressed) begin
                  state_q <= PRESS_WAIT;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!pressed) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_TERM) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
                  level_q <= 1'b1;
                  press_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            PRESSED: begin
               if (!pressed) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q <= '0;
`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
                  press_q <= repeatFire;
`endif
               end
            end
            RELEASE_WAIT: begin
               if (pressed) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_TERM) begin
                  state_q   <= IDLE;
                  cnt_q     <= '0;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign btn_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: stimulus queues expected pulses with their cycle
// numbers, an independent monitor matches every observed pulse against the queue.
module tb_button_debouncer;

   localparam int STABLE = 4;
   localparam int SYNC   = 2;
   // Raw edge driven after edge c gives its pulse after edge c + SYNC + STABLE.
   localparam int LAT    = SYNC + STABLE;

   typedef struct {
      bit    isPress;
      int    cyc;
      string name;
   } expEvent_t;

   logic clk;
   logic rst_n;
   logic btn_raw;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;

   expEvent_t expQ[$];
   int        cyc;
   int        testCount;
   int        failCount;

   button_debouncer #(
      .STABLE_CYCLES (STABLE),
      .SYNC_STAGES   (SYNC),
      .ACTIVE_LOW    (1'b1),
      .REPEAT_DELAY  (10),
      .REPEAT_PERIOD (3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_raw       (btn_raw),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic raw, input int cycles);
      btn_raw = raw;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic expectPulse(input bit isPress, input int atCyc, input string name);
      expEvent_t e;
      e.isPress = isPress;
      e.cyc     = atCyc;
      e.name    = name;
      expQ.push_back(e);
   endtask

   task automatic matchEvent(input bit isPress);
      expEvent_t e;
      testCount++;
      if (expQ.size() == 0) begin
         failCount++;
         $display("[TB] FAIL unexpected_pulse: got %s pulse at cycle %0d, expected none",
                  isPress ? "press" : "release", cyc);
      end else begin
         e = expQ.pop_front();
         if (e.isPress != isPress || e.cyc != cyc || btn_level !== isPress) begin
            failCount++;
            $display("[TB] FAIL %s: got %s pulse at cycle %0d level %b, expected %s at cycle %0d level %b",
                     e.name, isPress ? "press" : "release", cyc, btn_level,
                     e.isPress ? "press" : "release", e.cyc, e.isPress);
         end
      end
   endtask

   // Monitor: runs on the falling edge so registered outputs have settled.
   always @(negedge clk) begin
      if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
         testCount++;
         failCount++;
         $display("[TB] FAIL coincident_pulses: got press=1 release=1 at cycle %0d, expected at most one", cyc);
      end
      if (press_pulse === 1'b1) matchEvent(1'b1);
      if (release_pulse === 1'b1) matchEvent(1'b0);
   end

   initial begin
      cyc       = 0;
      testCount = 0;
      failCount = 0;
      rst_n     = 1'b0;
      btn_raw   = 1'b1;

      // Reset, then a released button must stay quiet.
      repeat (3) @(negedge clk);
      checkOutput("reset_level", btn_level, 1'b0);
      checkOutput("reset_press", press_pulse, 1'b0);
      checkOutput("reset_release", release_pulse, 1'b0);
      rst_n = 1'b1;
      applyStimulus(1'b1, 20);
      checkOutput("idle_level", btn_level, 1'b0);

      // Clean press.
      expectPulse(1'b1, cyc + LAT, "clean_press");
      applyStimulus(1'b0, 10);
      checkOutput("pressed_level", btn_level, 1'b1);

      // Release with a bounce back to pressed; only the final stable release counts.
      applyStimulus(1'b1, 2);
      applyStimulus(1'b0, 2);
      checkOutput("bounce_level_held", btn_level, 1'b1);
      expectPulse(1'b0, cyc + LAT, "bounced_release");
      applyStimulus(1'b1, 10);
      checkOutput("released_level", btn_level, 1'b0);

      // Short press glitches are rejected.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 3);
         applyStimulus(1'b1, 3);
      end
      applyStimulus(1'b1, 10);
      checkOutput("glitch_level", btn_level, 1'b0);

      // Reset mid-count with the button held through reset release.
      applyStimulus(1'b0, 4);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("midreset_level", btn_level, 1'b0);
      checkOutput("midreset_press", press_pulse, 1'b0);
      checkOutput("midreset_release", release_pulse, 1'b0);
      expectPulse(1'b1, cyc + LAT, "held_through_reset");
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("post_reset_level", btn_level, 1'b1);
      expectPulse(1'b0, cyc + LAT, "post_reset_release");
      applyStimulus(1'b1, 10);
      checkOutput("post_reset_released", btn_level, 1'b0);

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
      begin
         int accept;
         int repOffsets [6] = '{10, 13, 16, 19, 22, 25};
         accept = cyc + LAT;
         expectPulse(1'b1, accept, "repeat_accept");
         foreach (repOffsets[k]) expectPulse(1'b1, accept + repOffsets[k], "repeat_pulse");
         applyStimulus(1'b0, LAT + 25);
         checkOutput("repeat_level", btn_level, 1'b1);
         expectPulse(1'b0, cyc + LAT, "repeat_release");
         applyStimulus(1'b1, 20);
      end
`endif

      repeat (5) @(negedge clk);
      testCount++;
      if (expQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL pending_events: got %0d expected pulses never seen (first '%s' at cycle %0d), expected 0",
                  expQ.size(), expQ[0].name, expQ[0].cyc);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions one raw mechanical push-button input for the digital clock's mode/set logic.
- Synchronizes the input, filters contact bounce with a stability counter, and produces a clean level plus single-cycle press/release pulses.
- press_pulse drives the enable_debounced input of the downstream 2-bit mode counter directly: one pulse per physical press.

Parameters:
- STABLE_CYCLES, 500000, consecutive synchronized samples required before a level change is accepted (10 ms at 50 MHz); legal range 2..2^24-1.
- SYNC_STAGES, 2, flip-flop stages in the input synchronizer; legal range 2..4.
- ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed; 0 = reads 1 when pressed.
- REPEAT_DELAY, 50000000, hold cycles before the first auto-repeat pulse (used only with AUTOREPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (used only with AUTOREPEAT_EN).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_raw  input  1  asynchronous raw button pin
- btn_level  output  1  debounced level, 1 = pressed (polarity normalized)
- press_pulse  output  1  one-cycle pulse on accepted press (and on auto-repeat)
- release_pulse  output  1  one-cycle pulse on accepted release

Behaviour:
- Reset, async on rst_n low:
  - synchronizer chain loads the released value: 1 if ACTIVE_LOW, else 0.
  - FSM goes to IDLE, counter to 0.
  - btn_level, press_pulse and release_pulse are all 0.
- Input path:
  - btn_raw passes through SYNC_STAGES flops.
  - Then normalized: s = sync_out XOR ACTIVE_LOW, so s = 1 means pressed.
- Counter width: CNT_W = $clog2(STABLE_CYCLES+1). The counter saturates and never wraps.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: s=1 -> PRESS_WAIT with cnt=1; otherwise stay, cnt=0.
  - PRESS_WAIT, s=0 -> IDLE with cnt=0 (bounce rejected, no pulse).
  - PRESS_WAIT, s=1 and cnt==STABLE_CYCLES-1 -> PRESSED; press_pulse=1 and btn_level=1 from the next edge.
  - PRESS_WAIT, s=1 and not yet at terminal count -> cnt+1.
  - PRESSED: s=0 -> RELEASE_WAIT with cnt=1; otherwise hold.
  - RELEASE_WAIT, s=1 -> PRESSED with cnt=0 (no pulse).
  - RELEASE_WAIT, s=0 and cnt==STABLE_CYCLES-1 -> IDLE; release_pulse=1 and btn_level=0 from the next edge.
  - RELEASE_WAIT, s=0 and not yet at terminal count -> cnt+1.
- All outputs are registered.
  - Pulses last exactly one clk cycle.
  - btn_level changes in the same cycle its pulse is high.
- Latency:
  - A clean raw edge that is stable before clock edge k produces its pulse visible after edge k+SYNC_STAGES+STABLE_CYCLES-1.
  - The bench checks this relative to the first cycle s changes: pulse exactly STABLE_CYCLES cycles later.
- Boundaries:
  - A glitch shorter than STABLE_CYCLES samples produces no pulse and leaves btn_level unchanged.
  - A press and a release pulse never occur in the same cycle.
  - At most one press_pulse per press unless auto-repeat is enabled.
  - Reset asserted mid-count abandons the count; no pulse after reset is released until a full stable interval is observed.
  - A button held through reset release: post-reset s=1 -> PRESS_WAIT, then one press_pulse after STABLE_CYCLES.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a separate repeat counter (width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)) counts from entry into PRESSED.
  - First extra press_pulse at REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles while held.
  - The repeat counter clears on leaving PRESSED, including PRESSED -> RELEASE_WAIT; it does not restart on return to PRESSED from RELEASE_WAIT.
  - Repeat pulses do not affect btn_level.
- Undefined: no repeat logic or counter is synthesized; REPEAT_* are ignored and press_pulse fires once per press.

Decomposition:
- Shared package/include clock_pkg:
  - 2-bit FSM state encodings: IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3.
  - Default clock frequency constant CLK_FREQ_HZ=50000000, from which STABLE_CYCLES defaults are derived by the top level.
- One natural sub-module, bit_synchronizer: parameterized SYNC_STAGES flop chain with reset value parameter, reusable for other async inputs.

Test Plan (STABLE_CYCLES=4, SYNC_STAGES=2, ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Reset then btn_raw=1 for 20 cycles -> btn_level=0, no pulses, all outputs 0 during and after reset.
- btn_raw 1->0 held 10 cycles -> exactly one press_pulse, 4 cycles after s rises (6 after raw edge); btn_level=1 from that cycle.
- btn_raw pulsed 0 for 3 cycles then 1, repeated 5 times -> zero pulses, btn_level stays 0.
- From pressed, release with a 2-cycle bounce back to 0 then stable 1 -> single release_pulse 4 cycles after final stable s=0; no press_pulse.
- rst_n asserted after 2 counted press cycles, released with button still low -> no pulse during reset, one press_pulse exactly 4 cycles after post-reset s=1.
- With BUTTON_DEBOUNCER_AUTOREPEAT_EN, hold 25 cycles after accept -> press_pulses at accept, +10, +13, +16, +19, +22, +25; none after release.
